// File: rtl/mdu_div_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mdu_div_ctrl
//   Multi-cycle divide sequencer for the HI/LO unit. Runs DIV/DIVU as a
//   WIDTH-iteration restoring shift-subtract loop, owns the HI/LO registers,
//   services MTHI/MTLO writes, and raises a combinational stall toward the
//   pipeline while a divide is in flight.
//
//   Sequence: IDLE -> PREP -> ITER (WIDTH cycles) -> FIXUP -> IDLE.
//   Result and done pulse appear WIDTH+2 cycles after the start edge.
//
//   Optional feature macro: MDU_DIVZERO_FAST_EN
//     defined   : divisor==0 is caught in PREP and jumps directly to FIXUP
//     undefined : divisor==0 runs the full loop; same forced result
//   Divide-by-zero result in both builds: hi = dividend, lo = all ones.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   start, is_signed     issue DIV (is_signed=1) / DIVU (is_signed=0)
//   dividend, divisor    operands, sampled with start in IDLE
//   hilo_rd              MFHI/MFLO in decode (stalls while busy)
//   mthi_we, mtlo_we     HI/LO write strobes with wdata (IDLE only)
//   busy                 divide in progress
//   done                 one-cycle pulse after HI/LO are written by a divide
//   stall                hold PC/pipeline this cycle
//   hi, lo               HI (remainder) and LO (quotient) registers
// -----------------------------------------------------------------------------
module mdu_div_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             hilo_rd,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PREP  = 2'd1,
    ITER  = 2'd2,
    FIXUP = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_q,     a_d;     // original dividend (needed for /0 result)
  logic [WIDTH-1:0] b_q,     b_d;     // original divisor
  logic             sgn_q,   sgn_d;
  logic [WIDTH-1:0] rem_q,   rem_d;   // partial remainder
  logic [WIDTH-1:0] quo_q,   quo_d;   // dividend magnitude shifting into quotient
  logic [WIDTH-1:0] dvs_q,   dvs_d;   // divisor magnitude
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;
  logic             done_q,  done_d;

  // The shifted remainder can reach 2*divisor-1, so the trial subtract needs
  // one extra bit; a set MSB means the subtraction went negative (restore).
  logic [WIDTH:0] partial;
  logic [WIDTH:0] trial;

  assign partial = {rem_q, quo_q[WIDTH-1]};
  assign trial   = partial - {1'b0, dvs_q};

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves a variable
    // unassigned; that is what keeps this block free of inferred latches.
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Register writes and divide issue may share an edge; the divide
        // result overwrites later in FIXUP.
        if (mthi_we) hi_d = wdata;
        if (mtlo_we) lo_d = wdata;
        if (start) begin
          a_d     = dividend;
          b_d     = divisor;
          sgn_d   = is_signed;
          state_d = PREP;
        end
      end

      PREP: begin
        // Negating the most negative value wraps to itself, which is exactly
        // its unsigned magnitude.
        quo_d   = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
        dvs_d   = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
        q_neg_d = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        r_neg_d = sgn_q && a_q[WIDTH-1];
        rem_d   = '0;
        cnt_d   = '0;
        state_d = ITER;
`ifdef MDU_DIVZERO_FAST_EN
        if (b_q == '0) state_d = FIXUP;
`endif
      end

      ITER: begin
        rem_d = trial[WIDTH] ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = FIXUP;
      end

      FIXUP: begin
        if (b_q == '0) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = r_neg_q ? -rem_q : rem_q;
          lo_d = q_neg_q ? -quo_q : quo_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset clears every register, including HI/LO and the operand
  // latches, so an aborted divide can never leak a partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign stall = busy && (start || hilo_rd || mthi_we || mtlo_we);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
